// File: rtl/rom_arbiter.sv
// rom_arbiter: two requesters share one registered-address ROM through a three-stage read pipeline.
// Optional macro ROM_ARB_FIXED_PRIO_EN swaps round-robin arbitration for fixed priority (requester 0 wins).
module rom_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_enable_out,
  input  logic [DATA_W-1:0] rom_data
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic              addr_valid_reg;
  logic              addr_id_reg;
  logic              data_id_reg;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_vec [2];

  assign req = {req1, req0};

`ifdef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt[0] = req[0];
      gnt[1] = req[1] & ~req[0];
    end
  end
`else
  // Requester granted most recently; starts at 1 so the first contended grant goes to 0.
  logic last_reg;

  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      if (&req) begin
        gnt[0] = last_reg;
        gnt[1] = ~last_reg;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else if (gnt_any) begin
      last_reg <= gnt_id;
    end
  end
`endif

  assign gnt_any  = |gnt;
  assign gnt_id   = gnt[1];
  assign gnt_addr = gnt_id ? addr1 : addr0;
  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];

  // Address stage (C1) and ROM data stage (C2); rom_enable_out doubles as the C2 valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr       <= '0;
      addr_valid_reg <= 1'b0;
      addr_id_reg    <= 1'b0;
      rom_enable_out <= 1'b0;
      data_id_reg    <= 1'b0;
    end else begin
      if (gnt_any) begin
        rom_addr <= gnt_addr;
      end
      addr_valid_reg <= gnt_any;
      addr_id_reg    <= gnt_id;
      rom_enable_out <= addr_valid_reg;
      data_id_reg    <= addr_id_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      logic [DATA_W-1:0] rdata_reg;
      logic              rvalid_reg;
      logic              hit;

      assign hit = rom_enable_out && (data_id_reg == 1'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= hit;
          if (hit) begin
            rdata_reg <= rom_data;
          end
        end
      end

      assign rvalid_vec[gi] = rvalid_reg;
      assign rdata_vec[gi]  = rdata_reg;
    end
  endgenerate

  assign rvalid0 = rvalid_vec[0];
  assign rvalid1 = rvalid_vec[1];
  assign rdata0  = rdata_vec[0];
  assign rdata1  = rdata_vec[1];

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a grant-history model checks every cycle, directed scenarios pin literal values.
// Honours ROM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [5:0] addr0, addr1;
  logic       gnt0, gnt1;
  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1;
  logic [5:0] rom_addr;
  logic       rom_enable_out;
  logic [7:0] rom_data;

  int n_cmp = 0;
  int n_bad = 0;

  rom_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rom_addr(rom_addr), .rom_enable_out(rom_enable_out), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // External ROM: registered address, zero output while disabled.
  logic [7:0] rom_mem [64];
  logic [7:0] rom_q;
  always @(posedge clk) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_enable_out ? rom_q : 8'h00;

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: grant history indexed by cycle (0 = none, 1 = req0, 2 = req1).
  int         gid   [256];
  logic [5:0] gaddr [256];
  logic [7:0] gdata [256];
  int         cyc = 0;

  initial begin
    int         last;
    int         w;
    logic [5:0] exp_addr;
    logic       exp_en;
    logic [1:0] exp_rv;
    logic [7:0] exp_rd [2];
    last = 2;
    exp_addr = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    forever begin
      @(negedge clk);
      exp_rv = 2'b00;
      exp_en = 1'b0;
      w = 0;
      if (!reset) begin
        last = 2;
        exp_addr = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        gid[cyc] = 0;
        if (cyc >= 1) gid[cyc-1] = 0;
        if (cyc >= 2) gid[cyc-2] = 0;
      end else begin
        if (cyc >= 2) exp_en = (gid[cyc-2] != 0);
        if (cyc >= 1 && gid[cyc-1] != 0) exp_addr = gaddr[cyc-1];
        if (cyc >= 3 && gid[cyc-3] != 0) begin
          exp_rv[gid[cyc-3]-1] = 1'b1;
          exp_rd[gid[cyc-3]-1] = gdata[cyc-3];
        end
`ifdef ROM_ARB_FIXED_PRIO_EN
        if (req0) w = 1;
        else if (req1) w = 2;
`else
        if (req0 && req1) w = (last == 2) ? 1 : 2;
        else if (req0) w = 1;
        else if (req1) w = 2;
`endif
        gid[cyc] = w;
        if (w != 0) begin
          last = w;
          gaddr[cyc] = (w == 1) ? addr0 : addr1;
          gdata[cyc] = rom_mem[gaddr[cyc]];
        end
      end
      chk("gnt0", cyc, gnt0, w == 1);
      chk("gnt1", cyc, gnt1, w == 2);
      chk("rom_addr", cyc, rom_addr, exp_addr);
      chk("rom_enable_out", cyc, rom_enable_out, exp_en);
      chk("rvalid0", cyc, rvalid0, exp_rv[0]);
      chk("rvalid1", cyc, rvalid1, exp_rv[1]);
      chk("rdata0", cyc, rdata0, exp_rd[0]);
      chk("rdata1", cyc, rdata1, exp_rd[1]);
      cyc++;
      if (cyc >= 250) begin
        n_bad++;
        $display("FAIL cycle_budget cyc=%0d: got over budget want finish", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  task automatic drive(input logic r0, input logic [5:0] a0, input logic r1, input logic [5:0] a1);
    @(posedge clk);
    #1;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
  endtask

  initial begin
    logic [2:0] g0, g1;
    logic [7:0] st [5];
    int         pulses;
    st[0] = 8'h16; st[1] = 8'h3D; st[2] = 8'h1A; st[3] = 8'h08; st[4] = 8'h7F;
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'((i * 37 + 11) & 8'hFF);
    rom_mem[0] = 8'h41; rom_mem[1] = 8'h53; rom_mem[2] = 8'h52; rom_mem[3] = 8'h4D;
    rom_mem[4] = 8'h16; rom_mem[5] = 8'h3D; rom_mem[6] = 8'h1A; rom_mem[7] = 8'h08;
    rom_mem[8] = 8'h7F; rom_mem[15] = 8'h41;

    // Reset: grant suppressed even with a request pending.
    reset = 1'b0; req0 = 1'b1; addr0 = '0; req1 = 1'b0; addr1 = '0;
    @(negedge clk);
    chk("rst_gnt0", cyc, gnt0, 0);
    chk("rst_rom_addr", cyc, rom_addr, 0);
    @(posedge clk);
    #1 reset = 1'b1; req0 = 1'b0;

    // Contention, first contended grant after reset.
`ifdef ROM_ARB_FIXED_PRIO_EN
    g0 = 3'b111;
`else
    g0 = 3'b101;
`endif
    g1 = ~g0;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 6'h01, i < 3, 6'h03);
      @(negedge clk);
      if (i < 3) begin
        chk("cont_gnt0", i, gnt0, g0[i]);
        chk("cont_gnt1", i, gnt1, g1[i]);
      end else begin
        chk("cont_rvalid0", i, rvalid0, g0[i-3]);
        chk("cont_rvalid1", i, rvalid1, g1[i-3]);
        if (g1[i-3]) chk("cont_rdata1", i, rdata1, 8'h4D);
        else chk("cont_rdata0", i, rdata0, 8'h53);
      end
    end

    // Single read of 0x00.
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 6'h00, 1'b0, 6'h00);
      @(negedge clk);
      if (i == 0) chk("single_gnt0", i, gnt0, 1);
      if (i == 1) chk("single_rom_addr", i, rom_addr, 0);
      if (i == 2) chk("single_enable", i, rom_enable_out, 1);
      if (i == 3) begin
        chk("single_rvalid0", i, rvalid0, 1);
        chk("single_rdata0", i, rdata0, 8'h41);
      end
    end

    // Streaming on requester 1, addresses 0x04..0x08.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 6'h00, i < 5, 6'(4 + i));
      @(negedge clk);
      if (i >= 3 && i < 8) begin
        chk("stream_rvalid1", i, rvalid1, 1);
        chk("stream_rdata1", i, rdata1, st[i-3]);
      end
      if (i == 8) chk("stream_end_rvalid1", i, rvalid1, 0);
    end

    // One read of 0x02 then a long idle stretch.
    drive(1'b1, 6'h02, 1'b0, 6'h00);
    for (int i = 0; i < 12; i++) drive(1'b0, 6'h00, 1'b0, 6'h00);
    @(negedge clk);
    chk("idle_enable", 0, rom_enable_out, 0);
    chk("idle_rom_addr", 0, rom_addr, 6'h02);
    chk("idle_rdata0", 0, rdata0, 8'h52);

    // Reset in C1 of an in-flight read.
    drive(1'b1, 6'h0F, 1'b0, 6'h00);
    @(negedge clk);
    chk("mid_gnt0", 0, gnt0, 1);
    @(posedge clk);
    #1 req0 = 1'b0; reset = 1'b0;
    #1;
    chk("mid_rom_addr", 1, rom_addr, 0);
    chk("mid_rdata0", 1, rdata0, 0);
    chk("mid_rdata1", 1, rdata1, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 6'h00, 1'b0, 6'h00);
      @(negedge clk);
      if (rvalid0) pulses++;
    end
    chk("mid_no_stale_rvalid0", 0, pulses, 0);
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 6'h0F, 1'b0, 6'h00);
      @(negedge clk);
    end
    chk("fresh_rvalid0", 3, rvalid0, 1);
    chk("fresh_rdata0", 3, rdata0, 8'h41);

    drive(1'b0, 6'h00, 1'b0, 6'h00);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning ROM data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 each, the read request from requester 0/1.
REQ-006 SHALL have ports addr0/addr1, input, ADDR_W each, the read address from requester 0/1, held stable while its req is high.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each, the combinational grant to requester 0/1, meaning the request is accepted this cycle.
REQ-008 SHALL have ports rdata0/rdata1, output, DATA_W each, the registered read data for requester 0/1.
REQ-009 SHALL have ports rvalid0/rvalid1, output, 1 each, a one-cycle pulse marking rdata0/rdata1 valid.
REQ-010 SHALL have port rom_addr, output, ADDR_W, the registered address to the ROM.
REQ-011 SHALL have port rom_enable_out, output, 1, the ROM output enable, high only in the ROM data cycle of a granted read.
REQ-012 SHALL have port rom_data, input, DATA_W, the ROM output; the ROM registers its address and drives zero when its enable is low.

Function
REQ-013 SHALL grant at most one requester per cycle; gntN high only when reqN is high.
REQ-014 SHALL pipeline three stages: grant cycle C0, rom_addr loaded C1, rom_enable_out high C2 with rom_data captured at end of C2, rvalidN high C3.
REQ-015 SHALL accept a new grant every cycle; back-to-back reads SHALL return in grant order with no bubbles.
REQ-016 SHALL route each return only to the requester granted three cycles earlier; the other rvalid stays low and its rdata holds.
REQ-017 SHALL, when both req0 and req1 are high, use round-robin arbitration: grant the requester not granted most recently.
REQ-018 SHALL update the last-granted pointer only in cycles with a grant.
REQ-019 SHALL treat reqN still high in the cycle after gntN as a new request (requesters drop req or change addr after seeing gnt).
REQ-020 SHALL hold rom_addr at its last value when no grant occurs, with rom_enable_out low in the corresponding data cycle.
REQ-021 SHALL hold rdataN between rvalidN pulses.

Reset
REQ-022 SHALL, on reset low, asynchronously clear rom_addr, rdata0, rdata1, rvalid0, rvalid1, rom_enable_out and all pipeline-valid flags to 0.
REQ-023 SHALL reset the last-granted pointer to requester 1, so the first contended grant goes to requester 0.
REQ-024 SHALL force gnt0/gnt1 low while reset is low.
REQ-025 SHALL discard reads in flight when reset asserts mid-operation; no rvalid SHALL pulse for them after release.

Configuration
REQ-026 SHALL, with macro ROM_ARB_FIXED_PRIO_EN defined, replace round-robin with fixed priority: req0 always wins over req1.
REQ-027 SHALL, with ROM_ARB_FIXED_PRIO_EN undefined, use round-robin per REQ-017/REQ-018.

Verification
REQ-028 Scenario, single read: req0=1, addr0=0x00 for one cycle -> gnt0=1 in C0, rom_enable_out=1 in C2, rvalid0=1 with rdata0=0x41 in C3.
REQ-029 Scenario, contention: req0 and req1 high, addr0=0x01, addr1=0x03, held three cycles -> gnt0, gnt1, gnt0 in order; returns 0x53 (rvalid0), 0x4D (rvalid1), 0x53 (rvalid0) in consecutive cycles.
REQ-030 Scenario, fixed priority: same stimulus with ROM_ARB_FIXED_PRIO_EN defined -> gnt0 all three cycles, gnt1 never high, three rvalid0 pulses of 0x53.
REQ-031 Scenario, streaming: req1 high with addr1 stepping 0x04..0x08 one per cycle -> rvalid1 high five consecutive cycles with rdata1 0x16, 0x3D, 0x1A, 0x08, 0x7F.
REQ-032 Scenario, reset mid-flight: grant addr0=0x0F, assert reset in C1 for one cycle -> all outputs 0 immediately, no rvalid0 afterwards; a fresh read of 0x0F then returns 0x41.
REQ-033 Scenario, idle: no requests for 10 cycles after one read of 0x02 -> rom_enable_out stays 0, rom_addr holds 0x02, rdata0 holds 0x52.
